// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: AXI-stream byte source to GMII/MII transmit framer.
// Prepends preamble and SFD, serialises bytes (GMII) or low-first nibbles (MII)
// one slot per gmii_clk_en, flags bad frames and underflow on tx_er, and holds
// a minimum inter-frame gap before the next frame.
// Optional frame/error statistics ports: define GMII_TX_FRAMER_STATS_EN.
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,   // 0x55 bytes before the SFD, 1..15
    parameter int MIN_IFG      = 12   // idle slots between frames, 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        gmii_clk_en,
    input  logic        mii_select,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        start_packet,
    output logic        underflow
`ifdef GMII_TX_FRAMER_STATS_EN
    ,
    output logic [31:0] frame_count,
    output logic [15:0] error_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_UFLOW,    // error slot driven after a mid-frame underflow
        ST_DROP,
        ST_IFG
    } state_t;

    localparam logic [7:0] PRE_BYTE   = 8'h55;
    localparam logic [7:0] SFD_BYTE   = 8'hD5;
    localparam logic [3:0] PRE_RELOAD = 4'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IFG_RELOAD = 8'(MIN_IFG - 1);

    state_t      state_q, state_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        start_q, start_d;
    logic        uflow_q, uflow_d;
    logic [7:0]  byte_q, byte_d;       // byte of the slot on the wire; MII high nibble comes from here
    logic        phase_q, phase_d;     // MII only: 1 once the high nibble is on the wire
    logic        mii_q, mii_d;         // mode latched at frame start
    logic        last_q, last_d;       // byte on the wire closes the frame
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  ifg_cnt_q, ifg_cnt_d;

    logic        slot_end;
    logic        accept;
    logic        start_frame;
    logic        load;
    logic [7:0]  load_byte;

    // A slot ends on every enabled cycle in GMII, on the high-nibble cycle in MII.
    // Data is taken in the enabled cycle that closes the SFD or a non-final data slot;
    // while dropping, the remainder of the frame is drained regardless of gmii_clk_en.
    assign slot_end      = ~mii_q | phase_q;
    assign s_axis_tready = (state_q == ST_DROP) |
                           (gmii_clk_en & slot_end &
                            ((state_q == ST_SFD) | ((state_q == ST_DATA) & ~last_q)));
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Next-state and next-output decode; each enabled cycle either emits the
    // MII high nibble or closes the current slot and loads the next one.
    always_comb begin
        // NOTE: every variable is given a default before any branch so no path leaves it unassigned (no latches).
        state_d     = state_q;
        txd_d       = txd_q;
        tx_en_d     = tx_en_q;
        tx_er_d     = tx_er_q;
        start_d     = 1'b0;
        uflow_d     = 1'b0;
        byte_d      = byte_q;
        phase_d     = phase_q;
        mii_d       = mii_q;
        last_d      = last_q;
        pre_cnt_d   = pre_cnt_q;
        ifg_cnt_d   = ifg_cnt_q;
        start_frame = 1'b0;
        load        = 1'b0;
        load_byte   = 8'h00;

        if (state_q == ST_DROP) begin
            if (accept && s_axis_tlast) begin
                state_d   = ST_IFG;
                ifg_cnt_d = IFG_RELOAD;
                phase_d   = 1'b0;
            end
        end else if (gmii_clk_en) begin
            if ((state_q != ST_IDLE) && !slot_end) begin
                txd_d   = {4'h0, byte_q[7:4]};
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                case (state_q)
                    ST_IDLE: start_frame = s_axis_tvalid;
                    ST_PREAMBLE: begin
                        load = 1'b1;
                        if (pre_cnt_q == 4'd0) begin
                            state_d   = ST_SFD;
                            load_byte = SFD_BYTE;
                            start_d   = 1'b1;
                        end else begin
                            pre_cnt_d = pre_cnt_q - 4'd1;
                            load_byte = PRE_BYTE;
                        end
                    end
                    ST_SFD, ST_DATA: begin
                        load = 1'b1;
                        if ((state_q == ST_DATA) && last_q) begin
                            state_d   = ST_IFG;
                            ifg_cnt_d = IFG_RELOAD;
                            tx_en_d   = 1'b0;
                            tx_er_d   = 1'b0;
                        end else if (s_axis_tvalid) begin
                            state_d   = ST_DATA;
                            load_byte = s_axis_tdata;
                            last_d    = s_axis_tlast;
                            tx_er_d   = s_axis_tlast & s_axis_tuser;
                        end else begin
                            state_d = ST_UFLOW;
                            tx_er_d = 1'b1;
                            uflow_d = 1'b1;
                        end
                    end
                    ST_UFLOW: begin
                        load    = 1'b1;
                        state_d = ST_DROP;
                        tx_en_d = 1'b0;
                        tx_er_d = 1'b0;
                    end
                    ST_IFG: begin
                        if (ifg_cnt_q == 8'd0) begin
                            // The gap closes here; a waiting frame starts in this same slot.
                            if (s_axis_tvalid) start_frame = 1'b1;
                            else               state_d     = ST_IDLE;
                        end else begin
                            ifg_cnt_d = ifg_cnt_q - 8'd1;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end

        if (start_frame) begin
            state_d   = ST_PREAMBLE;
            mii_d     = mii_select;
            pre_cnt_d = PRE_RELOAD;
            tx_en_d   = 1'b1;
            tx_er_d   = 1'b0;
            load      = 1'b1;
            load_byte = PRE_BYTE;
        end

        if (load) begin
            byte_d = load_byte;
            txd_d  = mii_d ? {4'h0, load_byte[3:0]} : load_byte;
        end
    end

    // State and output registers; pulses clear every cycle, the rest hold unless decoded otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            txd_q     <= 8'h00;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            start_q   <= 1'b0;
            uflow_q   <= 1'b0;
            byte_q    <= 8'h00;
            phase_q   <= 1'b0;
            mii_q     <= 1'b0;
            last_q    <= 1'b0;
            pre_cnt_q <= 4'd0;
            ifg_cnt_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples values from before the edge.
            state_q   <= state_d;
            txd_q     <= txd_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            start_q   <= start_d;
            uflow_q   <= uflow_d;
            byte_q    <= byte_d;
            phase_q   <= phase_d;
            mii_q     <= mii_d;
            last_q    <= last_d;
            pre_cnt_q <= pre_cnt_d;
            ifg_cnt_q <= ifg_cnt_d;
        end
    end

    assign gmii_txd     = txd_q;
    assign gmii_tx_en   = tx_en_q;
    assign gmii_tx_er   = tx_er_q;
    assign start_packet = start_q;
    assign underflow    = uflow_q;

`ifdef GMII_TX_FRAMER_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] error_cnt_q;
    logic        frame_done;
    logic        frame_bad;

    // Outside DROP, any accepted tlast is the close of a transmitted frame.
    assign frame_done = accept & s_axis_tlast & (state_q != ST_DROP);
    assign frame_bad  = (frame_done & s_axis_tuser) | uflow_d;

    // Frame counter wraps, error counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= 32'd0;
            error_cnt_q <= 16'd0;
        end else begin
            if (frame_done) frame_cnt_q <= frame_cnt_q + 32'd1;
            if (frame_bad && (error_cnt_q != 16'hFFFF)) error_cnt_q <= error_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
    assign error_count = error_cnt_q;
`endif

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed self-checking bench for gmii_tx_framer (default parameters).
// Each enabled cycle's {tx_en, tx_er, txd} is logged and compared with hand-derived values.
`timescale 1ns/1ps
module tb_gmii_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic       s_axis_tuser;
    logic       gmii_clk_en;
    logic       mii_select;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       start_packet;
    logic       underflow;
`ifdef GMII_TX_FRAMER_STATS_EN
    logic [31:0] frame_count;
    logic [15:0] error_count;
`endif

    gmii_tx_framer dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .gmii_clk_en   (gmii_clk_en),
        .mii_select    (mii_select),
        .gmii_txd      (gmii_txd),
        .gmii_tx_en    (gmii_tx_en),
        .gmii_tx_er    (gmii_tx_er),
        .start_packet  (start_packet),
        .underflow     (underflow)
`ifdef GMII_TX_FRAMER_STATS_EN
        ,
        .frame_count   (frame_count),
        .error_count   (error_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hole;   // present tvalid=0 for one cycle
        logic       last;
        logic       user;
        logic [7:0] data;
    } beat_t;

    beat_t      src[$];
    logic [9:0] log_q[$];   // {tx_en, tx_er, txd} after each enabled edge
    int         n_checks = 0;
    int         n_errors = 0;
    int         sp_hi, uf_hi, sp_at, uf_at, hs_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic en, input logic er, input logic [7:0] d);
        return {22'd0, en, er, d};
    endfunction

    task automatic check_log(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] got;
        got = (idx < log_q.size()) ? {22'd0, log_q[idx]} : 32'hFFFF_FFFF;
        check(tag, got, exp);
    endtask

    function automatic int count_en();
        int n = 0;
        foreach (log_q[i]) if (log_q[i][9]) n++;
        return n;
    endfunction

    function automatic int idle_run(input int from);
        int n = 0;
        for (int i = from; i < log_q.size(); i++) begin
            if (log_q[i][9]) break;
            n++;
        end
        return n;
    endfunction

    task automatic push(input logic [7:0] d, input logic last, input logic user);
        src.push_back('{hole: 1'b0, last: last, user: user, data: d});
    endtask

    task automatic push_hole();
        src.push_back('{hole: 1'b1, last: 1'b0, user: 1'b0, data: 8'h00});
    endtask

    // One clock: drive the source head, settle, note the handshake, take the edge, log.
    task automatic step(input bit en);
        beat_t b;
        bit    hs;
        b = (src.size() > 0) ? src[0] : beat_t'('0);
        gmii_clk_en   = en;
        s_axis_tvalid = (src.size() > 0) && !b.hole;
        s_axis_tdata  = b.data;
        s_axis_tlast  = b.last;
        s_axis_tuser  = b.user;
        #1;
        hs = s_axis_tvalid && s_axis_tready;
        if ((src.size() > 0) && (b.hole || hs)) void'(src.pop_front());
        @(posedge clk);
        #1;
        if (hs) hs_cnt++;
        if (en) log_q.push_back({gmii_tx_en, gmii_tx_er, gmii_txd});
        if (start_packet) begin
            sp_hi++;
            if (sp_at < 0) sp_at = log_q.size() - 1;
        end
        if (underflow) begin
            uf_hi++;
            if (uf_at < 0) uf_at = log_q.size() - 1;
        end
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        gmii_clk_en   = 1'b1;
        mii_select    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        src.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        log_q.delete();
        sp_hi = 0; uf_hi = 0; sp_at = -1; uf_at = -1; hs_cnt = 0;
    endtask

    initial begin
        // Reset state, with the source and clock enable active during reset.
        rst = 1'b1; mii_select = 1'b0; gmii_clk_en = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'hFF; s_axis_tlast = 1'b1; s_axis_tuser = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {19'd0, start_packet, underflow, s_axis_tready, gmii_tx_en, gmii_tx_er, gmii_txd}, 32'd0);

        // GMII frame 11 22 33 44 then B1 B2 back to back; mii_select pulsed mid-frame.
        apply_reset();
        push(8'h11, 0, 0); push(8'h22, 0, 0); push(8'h33, 0, 0); push(8'h44, 1, 0);
        push(8'hB1, 0, 0); push(8'hB2, 1, 0);
        for (int k = 0; k < 40; k++) begin
            mii_select = (k >= 8) && (k < 15);
            step(1'b1);
        end
        check_log("g_pre_first", 0, ent(1, 0, 8'h55));
        check_log("g_pre_last", 6, ent(1, 0, 8'h55));
        check_log("g_sfd", 7, ent(1, 0, 8'hD5));
        check_log("g_d0", 8, ent(1, 0, 8'h11));
        check_log("g_d1", 9, ent(1, 0, 8'h22));
        check_log("g_d2", 10, ent(1, 0, 8'h33));
        check_log("g_d3", 11, ent(1, 0, 8'h44));
        check_log("g_ifg_first", 12, ent(0, 0, 8'h00));
        check("g_gap", idle_run(12), 12);
        check_log("g_b_pre", 24, ent(1, 0, 8'h55));
        check_log("g_b_sfd", 31, ent(1, 0, 8'hD5));
        check_log("g_b_d0", 32, ent(1, 0, 8'hB1));
        check_log("g_b_d1", 33, ent(1, 0, 8'hB2));
        check_log("g_b_end", 34, ent(0, 0, 8'h00));
        check("g_en_slots", count_en(), 22);
        check("g_sp_count", sp_hi, 2);
        check("g_sp_slot", sp_at, 7);
        check("g_uf_count", uf_hi, 0);

        // MII, clock enable every 10th cycle, single byte A7.
        apply_reset();
        mii_select = 1'b1;
        push(8'hA7, 1, 0);
        for (int k = 0; k < 200; k++) step((k % 10) == 0);
        for (int i = 0; i <= 14; i++) check_log($sformatf("m_pre%0d", i), i, ent(1, 0, 8'h05));
        check_log("m_sfd_hi", 15, ent(1, 0, 8'h0D));
        check_log("m_lo", 16, ent(1, 0, 8'h07));
        check_log("m_hi", 17, ent(1, 0, 8'h0A));
        check_log("m_end", 18, ent(0, 0, 8'h00));
        begin
            logic [3:0] upper = 4'h0;
            foreach (log_q[i]) upper |= log_q[i][7:4];
            check("m_upper_zero", upper, 0);
        end
        check("m_sp_count", sp_hi, 1);
        check("m_sp_slot", sp_at, 14);

        // Underflow after the second byte; remaining bytes are discarded.
        apply_reset();
        push(8'h01, 0, 0); push(8'h02, 0, 0);
        push_hole(); push_hole(); push_hole();
        push(8'h03, 0, 0); push(8'h04, 1, 0);
        for (int k = 0; k < 24; k++) step(1'b1);
        check_log("u_d0", 8, ent(1, 0, 8'h01));
        check_log("u_d1", 9, ent(1, 0, 8'h02));
        check_log("u_err_slot", 10, ent(1, 1, 8'h00));
        check_log("u_drop", 11, ent(0, 0, 8'h00));
        check("u_pulse_count", uf_hi, 1);
        check("u_pulse_slot", uf_at, 10);
        check("u_en_slots", count_en(), 11);
        check("u_drained", src.size(), 0);

        // MII with tuser on last byte 0x44; next frame waits 12 slots (24 nibbles).
        apply_reset();
        mii_select = 1'b1;
        push(8'h33, 0, 0); push(8'h44, 1, 1); push(8'h66, 1, 0);
        for (int k = 0; k < 50; k++) step(1'b1);
        check_log("e_sfd_hi", 15, ent(1, 0, 8'h0D));
        check_log("e_d0_lo", 16, ent(1, 0, 8'h03));
        check_log("e_d0_hi", 17, ent(1, 0, 8'h03));
        check_log("e_bad_lo", 18, ent(1, 1, 8'h04));
        check_log("e_bad_hi", 19, ent(1, 1, 8'h04));
        check_log("e_ifg", 20, ent(0, 0, 8'h00));
        check("e_gap", idle_run(20), 24);
        check_log("e_next_pre", 44, ent(1, 0, 8'h05));

        // Reset during DATA; next frame starts with no gap.
        apply_reset();
        for (int i = 0; i < 6; i++) push(8'hA1 + 8'(i), i == 5, 0);
        for (int k = 0; k < 10; k++) step(1'b1);
        check_log("r_in_data", 9, ent(1, 0, 8'hA2));
        rst = 1'b1;
        src.delete();
        step(1'b1);
        check_log("r_outputs", 10, ent(0, 0, 8'h00));
        s_axis_tvalid = 1'b1;
        #1;
        check("r_tready", s_axis_tready, 0);
        rst = 1'b0;
        push(8'h77, 1, 0);
        step(1'b1);
        check_log("r_no_gap", 11, ent(1, 0, 8'h55));

        // Clock enable stuck low mid-frame: no handshakes, outputs hold.
        apply_reset();
        push(8'h81, 0, 0); push(8'h82, 1, 0);
        for (int k = 0; k < 9; k++) step(1'b1);
        check_log("f_d0", 8, ent(1, 0, 8'h81));
        for (int k = 0; k < 20; k++) step(1'b0);
        check("f_handshakes", hs_cnt, 1);
        check("f_hold", {22'd0, gmii_tx_en, gmii_tx_er, gmii_txd}, ent(1, 0, 8'h81));
        step(1'b1);
        check_log("f_resume", 9, ent(1, 0, 8'h82));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
